poly_mult_rlwe: RTL and testbench
=================================

POLY_MULT_RLWE -- requirements
Module: poly_mult_rlwe

Interface
REQ-001 Parameter BIT_WIDTH, default `BIT_WIDTH: width of one coefficient.
REQ-002 Parameter LINE_SIZE, default `LINE_SIZE: coefficients per RAM line.
REQ-003 Parameter ADDR_WIDTH, default `ADDR_WIDTH: line-address width.
REQ-004 Parameter MULT_LAT, default 3: modular-multiplier pipeline depth, in cycles (>=1).
REQ-005 The block SHALL use one clock, and its reset SHALL be synchronous and active-high.
REQ-006 Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- q  in  BIT_WIDTH  modulus
- length  in  ADDR_WIDTH+log2(LINE_SIZE)  coefficients per polynomial
- in_empty  in  1  input NTT buffer holds no polynomial
- in_rd_finish  out  1  one-cycle pulse that pops the input polynomial
- in_addrA/in_addrB  out  ADDR_WIDTH each  input read addresses (even/odd line)
- in_dA/in_dB  in  BIT_WIDTH*LINE_SIZE each  input read data, 1-cycle read latency
- in_rlwe_id/in_poly_id/in_opcode  in  `RLWE_ID_WIDTH/1/`OPCODE_WIDTH  input polynomial metadata
- key_addrA/key_addrB  out  ADDR_WIDTH each  key RAM read addresses
- key_doutA/key_doutB  in  BIT_WIDTH*LINE_SIZE each  key data, 1-cycle latency
- out_full  in  1  output (accumulator-side) FIFO has no free slot
- out_we  out  1  output write enable
- out_addrA/out_addrB  out  ADDR_WIDTH each  output write addresses
- out_dA/out_dB  out  BIT_WIDTH*LINE_SIZE each  products
- out_rlwe_id/out_poly_id/out_opcode  out  as the in_ ports  metadata of the polynomial being written
- out_wr_finish  out  1  one-cycle pulse that pushes the output slot

Function
REQ-007 Every coefficient lane SHALL produce out = (in * key) mod q, with inputs < q and output < q.
REQ-008 States SHALL be IDLE, RUN, FLUSH, DONE.
REQ-009 IDLE->RUN SHALL occur only when !in_empty && !out_full; metadata SHALL be latched on this transition.
REQ-010 In RUN, the address pair SHALL start at (0,1) and advance by 2 on both ports each cycle; key addresses SHALL equal input addresses.
REQ-011 RUN->FLUSH SHALL occur in the cycle that issues in_addrB == length/LINE_SIZE-1.
REQ-012 A write SHALL reach out_* exactly 1+MULT_LAT cycles after its read address was issued, with out_addrA/B equal to the issued addresses and out_we=1.
REQ-013 FLUSH->DONE SHALL occur once the last pair has been written; DONE SHALL pulse in_rd_finish and out_wr_finish together for 1 cycle, then return to IDLE.
REQ-014 out_full SHALL be sampled only in IDLE; a slot, once started, SHALL be completed even if out_full rises mid-polynomial.
REQ-015 The minimum legal length SHALL be 2*LINE_SIZE (one pair); that case SHALL go RUN->FLUSH after one cycle.
REQ-016 Back-to-back polynomials SHALL be allowed: after DONE, IDLE SHALL restart on the next cycle if the start conditions hold.
REQ-017 Outside RUN/FLUSH-pipeline writes, out_we SHALL be 0; in_rd_finish and out_wr_finish SHALL be 0 outside DONE.

Reset
REQ-018 rst SHALL force IDLE, zero the addresses, clear the pipeline valid bits, and drive out_we=0, in_rd_finish=0, out_wr_finish=0 on the next edge.
REQ-019 A reset issued mid-polynomial SHALL abort the polynomial with no finish pulses and no further writes.
REQ-020 Datapath pipeline registers SHALL NOT require reset.

Structure
REQ-021 The state enum, the opcode/poly_id constants and the width macros SHALL live in the shared common package/header.
REQ-022 A single sub-module, mod_mult (pipelined, MULT_LAT stages), SHALL be instantiated 2*LINE_SIZE times.
REQ-023 A valid/address shift register of depth 1+MULT_LAT SHALL track in-flight pairs.

Verification
REQ-024 Single polynomial: q=17, length=2*LINE_SIZE, in coefficients all 5, key coefficients all 7 -> one write at addresses (0,1) with every lane 1, then one finish pulse.
REQ-025 Full length: length=`MAX_LEN, random data -> length/(2*LINE_SIZE) writes with addresses 0..lines-1 in order, bit-exact against the reference model, and write latency 1+MULT_LAT.
REQ-026 Backpressure: out_full=1 with in_empty=0 -> the block stays in IDLE with no reads; when out_full drops, processing starts; out_full raised mid-run -> the polynomial still completes.
REQ-027 Back-to-back: two queued polynomials with different rlwe_id -> two finish pulses, the metadata on out_* matches each polynomial, and there is no idle gap beyond DONE->IDLE.
REQ-028 Reset mid-run at pair 3 -> no finish pulse, out_we=0 from the next cycle, and the next polynomial is processed correctly from address 0.
REQ-029 Edge operands: lanes with q-1 × q-1 -> 1, and 0 × x -> 0.

Source files
------------

// File: rtl/poly_mult_rlwe_pkg.sv
// poly_mult_rlwe_pkg: shared definitions for the RLWE polynomial multiplier.
//   - width macros (BIT_WIDTH, LINE_SIZE, ADDR_WIDTH, RLWE_ID_WIDTH, OPCODE_WIDTH, MAX_LEN)
//   - matching typed localparams, FSM state enum, opcode and poly_id constants
`ifndef POLY_MULT_RLWE_DEFINES
`define POLY_MULT_RLWE_DEFINES
`define BIT_WIDTH     16
`define LINE_SIZE     4
`define ADDR_WIDTH    4
`define RLWE_ID_WIDTH 4
`define OPCODE_WIDTH  2
// Lines are consumed in even/odd pairs and the line count must fit in the
// length port, so the largest usable polynomial stops two lines short.
`define MAX_LEN       (`LINE_SIZE * ((1 << `ADDR_WIDTH) - 2))
`endif

package poly_mult_rlwe_pkg;

   localparam int unsigned DefBitWidth  = `BIT_WIDTH;
   localparam int unsigned DefLineSize  = `LINE_SIZE;
   localparam int unsigned DefAddrWidth = `ADDR_WIDTH;
   localparam int unsigned RlweIdWidth  = `RLWE_ID_WIDTH;
   localparam int unsigned OpcodeWidth  = `OPCODE_WIDTH;
   localparam int unsigned MaxLen       = `MAX_LEN;

   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StFlush,
      StDone
   } state_e;

   localparam logic PolyIdA = 1'b0;
   localparam logic PolyIdB = 1'b1;

   localparam logic [OpcodeWidth-1:0] OpMult    = OpcodeWidth'(0);
   localparam logic [OpcodeWidth-1:0] OpMultAcc = OpcodeWidth'(1);

endpackage

// File: rtl/poly_mult_rlwe_mod_mult.sv
// poly_mult_rlwe_mod_mult: pipelined modular multiplier, p = (a * b) mod q.
//   clk  in  clock
//   i_a  in  BIT_WIDTH  operand (< q)
//   i_b  in  BIT_WIDTH  operand (< q)
//   i_q  in  BIT_WIDTH  modulus
//   o_p  out BIT_WIDTH  product, valid MULT_LAT cycles after the operands
// The pipeline carries no valid bits and needs no reset; the caller tracks validity.
module poly_mult_rlwe_mod_mult #(
   parameter int unsigned BIT_WIDTH = 16,
   parameter int unsigned MULT_LAT  = 3
) (
   input  logic                 clk,
   input  logic [BIT_WIDTH-1:0] i_a,
   input  logic [BIT_WIDTH-1:0] i_b,
   input  logic [BIT_WIDTH-1:0] i_q,
   output logic [BIT_WIDTH-1:0] o_p
);

   logic [BIT_WIDTH-1:0] r_pipe [MULT_LAT];

   always_ff @(posedge clk) begin
      // Full-width product, reduced in the first stage; later stages only delay.
      r_pipe[0] <= BIT_WIDTH'(({{BIT_WIDTH{1'b0}}, i_a} * {{BIT_WIDTH{1'b0}}, i_b})
                             % {{BIT_WIDTH{1'b0}}, i_q});
      for (int i = 1; i < MULT_LAT; i++) begin
         r_pipe[i] <= r_pipe[i-1];
      end
   end

   assign o_p = r_pipe[MULT_LAT-1];

endmodule

// File: rtl/poly_mult_rlwe.sv
// poly_mult_rlwe: lane-parallel pointwise modular multiply of an NTT polynomial by a key.
//   clk, rst                      clock, synchronous active-high reset
//   q, length                     modulus, coefficients per polynomial
//   in_empty / in_rd_finish       input buffer status / pop pulse
//   in_addrA/B, in_dA/B           input RAM even/odd line read (1-cycle latency)
//   in_rlwe_id/poly_id/opcode     input metadata, latched at start
//   key_addrA/B, key_doutA/B      key RAM read (1-cycle latency)
//   out_full                      output FIFO full, sampled only while idle
//   out_we, out_addrA/B, out_dA/B output line-pair writes
//   out_rlwe_id/poly_id/opcode    metadata of the polynomial being written
//   out_wr_finish                 output push pulse, coincident with in_rd_finish
module poly_mult_rlwe
   import poly_mult_rlwe_pkg::*;
#(
   parameter int unsigned BIT_WIDTH  = DefBitWidth,
   parameter int unsigned LINE_SIZE  = DefLineSize,
   parameter int unsigned ADDR_WIDTH = DefAddrWidth,
   parameter int unsigned MULT_LAT   = 3,
   localparam int unsigned LineBits  = BIT_WIDTH * LINE_SIZE,
   localparam int unsigned LenWidth  = ADDR_WIDTH + $clog2(LINE_SIZE)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [BIT_WIDTH-1:0]   q,
   input  logic [LenWidth-1:0]    length,
   input  logic                   in_empty,
   output logic                   in_rd_finish,
   output logic [ADDR_WIDTH-1:0]  in_addrA,
   output logic [ADDR_WIDTH-1:0]  in_addrB,
   input  logic [LineBits-1:0]    in_dA,
   input  logic [LineBits-1:0]    in_dB,
   input  logic [RlweIdWidth-1:0] in_rlwe_id,
   input  logic                   in_poly_id,
   input  logic [OpcodeWidth-1:0] in_opcode,
   output logic [ADDR_WIDTH-1:0]  key_addrA,
   output logic [ADDR_WIDTH-1:0]  key_addrB,
   input  logic [LineBits-1:0]    key_doutA,
   input  logic [LineBits-1:0]    key_doutB,
   input  logic                   out_full,
   output logic                   out_we,
   output logic [ADDR_WIDTH-1:0]  out_addrA,
   output logic [ADDR_WIDTH-1:0]  out_addrB,
   output logic [LineBits-1:0]    out_dA,
   output logic [LineBits-1:0]    out_dB,
   output logic [RlweIdWidth-1:0] out_rlwe_id,
   output logic                   out_poly_id,
   output logic [OpcodeWidth-1:0] out_opcode,
   output logic                   out_wr_finish
);

   localparam int unsigned PairWidth = ADDR_WIDTH - 1;
   localparam int unsigned LogLine   = $clog2(LINE_SIZE);

   state_e                 r_state;
   state_e                 w_state_next;
   logic                   w_start;
   logic                   w_last_pair;
   logic [PairWidth-1:0]   r_pair;
   // Stage i holds the pair issued i+1 cycles ago; stage MULT_LAT drives the write.
   logic [MULT_LAT:0]      r_valid;
   logic [PairWidth-1:0]   r_vpair [MULT_LAT+1];
   logic [RlweIdWidth-1:0] r_rlwe_id;
   logic                   r_poly_id;
   logic [OpcodeWidth-1:0] r_opcode;

   // Odd line of the current pair is the last line of the polynomial.
   assign w_last_pair = (LenWidth'({r_pair, 1'b1}) == (length >> LogLine) - LenWidth'(1));

   always_comb begin
      w_state_next = r_state;
      w_start      = 1'b0;
      case (r_state)
         StIdle: begin
            if (!in_empty && !out_full) begin
               w_state_next = StRun;
               w_start      = 1'b1;
            end
         end
         StRun: begin
            if (w_last_pair) w_state_next = StFlush;
         end
         StFlush: begin
            // Only the output stage may still be busy: the last write is this cycle.
            if (!(|r_valid[MULT_LAT-1:0])) w_state_next = StDone;
         end
         StDone:  w_state_next = StIdle;
         default: w_state_next = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= StIdle;
         r_pair    <= '0;
         r_valid   <= '0;
         r_rlwe_id <= '0;
         r_poly_id <= 1'b0;
         r_opcode  <= '0;
      end else begin
         r_state <= w_state_next;
         r_valid <= {r_valid[MULT_LAT-1:0], r_state == StRun};
         if (r_state == StRun) begin
            r_pair <= w_last_pair ? '0 : r_pair + PairWidth'(1);
         end
         if (w_start) begin
            r_rlwe_id <= in_rlwe_id;
            r_poly_id <= in_poly_id;
            r_opcode  <= in_opcode;
         end
      end
   end

   always_ff @(posedge clk) begin
      r_vpair[0] <= r_pair;
      for (int i = 1; i <= MULT_LAT; i++) begin
         r_vpair[i] <= r_vpair[i-1];
      end
   end

   assign in_addrA  = {r_pair, 1'b0};
   assign in_addrB  = {r_pair, 1'b1};
   assign key_addrA = {r_pair, 1'b0};
   assign key_addrB = {r_pair, 1'b1};

   assign out_we      = r_valid[MULT_LAT];
   assign out_addrA   = {r_vpair[MULT_LAT], 1'b0};
   assign out_addrB   = {r_vpair[MULT_LAT], 1'b1};
   assign out_rlwe_id = r_rlwe_id;
   assign out_poly_id = r_poly_id;
   assign out_opcode  = r_opcode;

   assign in_rd_finish  = (r_state == StDone);
   assign out_wr_finish = (r_state == StDone);

   for (genvar g = 0; g < LINE_SIZE; g++) begin : g_lane
      poly_mult_rlwe_mod_mult #(
         .BIT_WIDTH(BIT_WIDTH),
         .MULT_LAT (MULT_LAT)
      ) u_mod_mult_a (
         .clk(clk),
         .i_a(in_dA[g*BIT_WIDTH +: BIT_WIDTH]),
         .i_b(key_doutA[g*BIT_WIDTH +: BIT_WIDTH]),
         .i_q(q),
         .o_p(out_dA[g*BIT_WIDTH +: BIT_WIDTH])
      );
      poly_mult_rlwe_mod_mult #(
         .BIT_WIDTH(BIT_WIDTH),
         .MULT_LAT (MULT_LAT)
      ) u_mod_mult_b (
         .clk(clk),
         .i_a(in_dB[g*BIT_WIDTH +: BIT_WIDTH]),
         .i_b(key_doutB[g*BIT_WIDTH +: BIT_WIDTH]),
         .i_q(q),
         .o_p(out_dB[g*BIT_WIDTH +: BIT_WIDTH])
      );
   end

endmodule

// File: tb/tb_poly_mult_rlwe.sv
// tb_poly_mult_rlwe: directed/randomised bench for poly_mult_rlwe with a two-entry
// input buffer model, shared key RAM and an arithmetic reference model.
module tb_poly_mult_rlwe;
   import poly_mult_rlwe_pkg::*;

   localparam int unsigned BW = DefBitWidth;
   localparam int unsigned LS = DefLineSize;
   localparam int unsigned AW = DefAddrWidth;
   localparam int unsigned ML = 3;
   localparam int unsigned LB = BW * LS;
   localparam int unsigned LW = AW + $clog2(LS);
   localparam int unsigned NL = 1 << AW;

   logic                   clk = 1'b0;
   logic                   rst;
   logic [BW-1:0]          q;
   logic [LW-1:0]          length;
   logic                   in_empty;
   logic                   in_rd_finish;
   logic [AW-1:0]          in_addrA, in_addrB;
   logic [LB-1:0]          in_dA, in_dB;
   logic [RlweIdWidth-1:0] in_rlwe_id;
   logic                   in_poly_id;
   logic [OpcodeWidth-1:0] in_opcode;
   logic [AW-1:0]          key_addrA, key_addrB;
   logic [LB-1:0]          key_doutA, key_doutB;
   logic                   out_full;
   logic                   out_we;
   logic [AW-1:0]          out_addrA, out_addrB;
   logic [LB-1:0]          out_dA, out_dB;
   logic [RlweIdWidth-1:0] out_rlwe_id;
   logic                   out_poly_id;
   logic [OpcodeWidth-1:0] out_opcode;
   logic                   out_wr_finish;

   poly_mult_rlwe #(
      .BIT_WIDTH (BW),
      .LINE_SIZE (LS),
      .ADDR_WIDTH(AW),
      .MULT_LAT  (ML)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .q            (q),
      .length       (length),
      .in_empty     (in_empty),
      .in_rd_finish (in_rd_finish),
      .in_addrA     (in_addrA),
      .in_addrB     (in_addrB),
      .in_dA        (in_dA),
      .in_dB        (in_dB),
      .in_rlwe_id   (in_rlwe_id),
      .in_poly_id   (in_poly_id),
      .in_opcode    (in_opcode),
      .key_addrA    (key_addrA),
      .key_addrB    (key_addrB),
      .key_doutA    (key_doutA),
      .key_doutB    (key_doutB),
      .out_full     (out_full),
      .out_we       (out_we),
      .out_addrA    (out_addrA),
      .out_addrB    (out_addrB),
      .out_dA       (out_dA),
      .out_dB       (out_dB),
      .out_rlwe_id  (out_rlwe_id),
      .out_poly_id  (out_poly_id),
      .out_opcode   (out_opcode),
      .out_wr_finish(out_wr_finish)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Two-entry input buffer: banks alternate on push and on pop.
   logic [LB-1:0]          in_mem  [2][NL];
   logic [LB-1:0]          key_mem [NL];
   logic [RlweIdWidth-1:0] meta_rid [2];
   logic                   meta_pid [2];
   logic [OpcodeWidth-1:0] meta_op  [2];
   int                     n_pushed = 0;
   int                     n_popped = 0;

   assign in_empty   = (n_pushed == n_popped);
   assign in_rlwe_id = meta_rid[n_popped % 2];
   assign in_poly_id = meta_pid[n_popped % 2];
   assign in_opcode  = meta_op[n_popped % 2];

   always @(posedge clk) begin
      if (in_rd_finish) n_popped <= n_popped + 1;
      in_dA     <= in_mem[n_popped % 2][in_addrA];
      in_dB     <= in_mem[n_popped % 2][in_addrB];
      key_doutA <= key_mem[key_addrA];
      key_doutB <= key_mem[key_addrB];
   end

   typedef struct {
      int                     cyc;
      logic [AW-1:0]          a;
      logic [AW-1:0]          b;
      logic [LB-1:0]          da;
      logic [LB-1:0]          db;
      logic [RlweIdWidth-1:0] rid;
      logic                   pid;
      logic [OpcodeWidth-1:0] op;
   } wr_t;

   wr_t wr_q[$];
   int  fin_q[$];
   int  key_bad = 0;
   int  fin_bad = 0;

   always @(negedge clk) begin
      if (out_we) begin
         wr_q.push_back('{cyc, out_addrA, out_addrB, out_dA, out_dB,
                          out_rlwe_id, out_poly_id, out_opcode});
      end
      if (in_rd_finish) fin_q.push_back(cyc);
      if (in_rd_finish !== out_wr_finish) fin_bad++;
      if (key_addrA !== in_addrA || key_addrB !== in_addrB) key_bad++;
   end

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: every lane is (in * key) mod q in plain integer arithmetic.
   function automatic logic [LB-1:0] ref_line(input int bank, input int line);
      logic [LB-1:0]   r;
      longint unsigned a;
      longint unsigned k;
      r = '0;
      for (int i = 0; i < LS; i++) begin
         a = longint'(in_mem[bank][line][i*BW +: BW]);
         k = longint'(key_mem[line][i*BW +: BW]);
         r[i*BW +: BW] = BW'((a * k) % longint'(q));
      end
      return r;
   endfunction

   // mode 0: constants, 1: random < q, 2: alternate (q-1)*(q-1) and 0*random lanes.
   // The key RAM is shared, so it is rewritten on every push.
   task automatic push_poly(input logic [RlweIdWidth-1:0] rid, input logic pid,
                            input logic [OpcodeWidth-1:0] op, input int mode,
                            input int cin, input int ckey);
      int b;
      b = n_pushed % 2;
      for (int l = 0; l < NL; l++) begin
         for (int i = 0; i < LS; i++) begin
            if (mode == 0) begin
               in_mem[b][l][i*BW +: BW] = BW'(cin);
               key_mem[l][i*BW +: BW]   = BW'(ckey);
            end else if (mode == 1) begin
               in_mem[b][l][i*BW +: BW] = BW'($urandom_range(int'(q) - 1));
               key_mem[l][i*BW +: BW]   = BW'($urandom_range(int'(q) - 1));
            end else if (i % 2 == 0) begin
               in_mem[b][l][i*BW +: BW] = q - BW'(1);
               key_mem[l][i*BW +: BW]   = q - BW'(1);
            end else begin
               in_mem[b][l][i*BW +: BW] = '0;
               key_mem[l][i*BW +: BW]   = BW'($urandom_range(int'(q) - 1));
            end
         end
      end
      meta_rid[b] = rid;
      meta_pid[b] = pid;
      meta_op[b]  = op;
      n_pushed++;
   endtask

   // Polynomial seen by the block idle-and-ready during cycle c0 starts issuing at c0+1.
   task automatic check_poly(input string tag, input int c0, input int bank,
                             input logic [RlweIdWidth-1:0] rid, input logic pid,
                             input logic [OpcodeWidth-1:0] op);
      int  pairs;
      wr_t w;
      pairs = int'(length) / (2 * LS);
      for (int p = 0; p < pairs; p++) begin
         if (wr_q.size() == 0) begin
            chk({tag, " write count"}, 64'(p), 64'(pairs));
            break;
         end
         w = wr_q.pop_front();
         chk({tag, " write cycle"}, 64'(w.cyc), 64'(c0 + 2 + ML + p));
         chk({tag, " addrA"}, 64'(w.a), 64'(2 * p));
         chk({tag, " addrB"}, 64'(w.b), 64'(2 * p + 1));
         chk({tag, " dA"}, w.da, ref_line(bank, 2 * p));
         chk({tag, " dB"}, w.db, ref_line(bank, 2 * p + 1));
         chk({tag, " meta"}, 64'({w.rid, w.pid, w.op}), 64'({rid, pid, op}));
      end
      if (fin_q.size() == 0) begin
         chk({tag, " finish count"}, 64'(0), 64'(1));
      end else begin
         chk({tag, " finish cycle"}, 64'(fin_q.pop_front()), 64'(c0 + pairs + 2 + ML));
      end
   endtask

   task automatic chk_drained(input string tag);
      chk({tag, " extra writes"}, 64'(wr_q.size()), 64'(0));
      chk({tag, " extra finishes"}, 64'(fin_q.size()), 64'(0));
      wr_q.delete();
      fin_q.delete();
   endtask

   logic [LB-1:0] ones;
   int            c0;
   int            b0;
   int            b1;
   int            pairs;

   initial begin
      rst      = 1'b1;
      out_full = 1'b0;
      q        = BW'(17);
      length   = LW'(2 * LS);
      ones     = {LS{BW'(1)}};
      repeat (3) @(negedge clk);
      chk("reset out_we", 64'(out_we), 64'(0));
      chk("reset in_rd_finish", 64'(in_rd_finish), 64'(0));
      chk("reset out_wr_finish", 64'(out_wr_finish), 64'(0));
      chk("reset in_addrA", 64'(in_addrA), 64'(0));
      chk("reset in_addrB", 64'(in_addrB), 64'(1));
      rst = 1'b0;

      // Single pair: 5*7 mod 17 = 1 in every lane.
      @(negedge clk);
      c0 = cyc;
      b0 = n_pushed % 2;
      push_poly(4'h1, PolyIdA, OpMult, 0, 5, 7);
      repeat (15) @(negedge clk);
      if (wr_q.size() > 0) chk("single lanes dA", wr_q[0].da, ones);
      if (wr_q.size() > 0) chk("single lanes dB", wr_q[0].db, ones);
      check_poly("single", c0, b0, 4'h1, PolyIdA, OpMult);
      chk_drained("single");

      // Full length, random data.
      q      = BW'(12289);
      length = LW'(MaxLen);
      @(negedge clk);
      c0 = cyc;
      b0 = n_pushed % 2;
      push_poly(4'h2, PolyIdB, OpMultAcc, 1, 0, 0);
      repeat (30) @(negedge clk);
      check_poly("full", c0, b0, 4'h2, PolyIdB, OpMultAcc);
      chk_drained("full");

      // Backpressure: held in idle while full, then full rises mid-run.
      q        = BW'(3329);
      length   = LW'(6 * LS);
      out_full = 1'b1;
      @(negedge clk);
      b0 = n_pushed % 2;
      push_poly(4'h3, PolyIdA, OpMult, 1, 0, 0);
      repeat (10) @(negedge clk);
      chk("bp no writes", 64'(wr_q.size()), 64'(0));
      chk("bp no finish", 64'(fin_q.size()), 64'(0));
      chk("bp not popped", 64'(in_empty), 64'(0));
      @(negedge clk);
      c0       = cyc;
      out_full = 1'b0;
      repeat (2) @(negedge clk);
      out_full = 1'b1;
      repeat (20) @(negedge clk);
      out_full = 1'b0;
      check_poly("bp", c0, b0, 4'h3, PolyIdA, OpMult);
      chk_drained("bp");

      // Back-to-back: second starts the cycle after DONE->IDLE.
      q      = BW'(65521);
      length = LW'(6 * LS);
      pairs  = 3;
      @(negedge clk);
      c0 = cyc;
      b0 = n_pushed % 2;
      push_poly(4'h5, PolyIdA, OpMult, 1, 0, 0);
      b1 = n_pushed % 2;
      push_poly(4'h9, PolyIdB, OpMultAcc, 1, 0, 0);
      repeat (40) @(negedge clk);
      check_poly("b2b first", c0, b0, 4'h5, PolyIdA, OpMult);
      check_poly("b2b second", c0 + pairs + 2 + ML + 1, b1, 4'h9, PolyIdB, OpMultAcc);
      chk_drained("b2b");

      // Reset while pair 3 is issued; the aborted polynomial is rerun from address 0.
      q      = BW'(3329);
      length = LW'(MaxLen);
      @(negedge clk);
      c0 = cyc;
      b0 = n_pushed % 2;
      push_poly(4'h6, PolyIdB, OpMult, 1, 0, 0);
      repeat (4) @(negedge clk);
      chk("rst pair3 addrA", 64'(in_addrA), 64'(6));
      rst = 1'b1;
      @(negedge clk);
      chk("rst out_we", 64'(out_we), 64'(0));
      chk("rst in_rd_finish", 64'(in_rd_finish), 64'(0));
      repeat (2) @(negedge clk);
      chk("rst no writes", 64'(wr_q.size()), 64'(0));
      chk("rst no finish", 64'(fin_q.size()), 64'(0));
      c0  = cyc;
      rst = 1'b0;
      repeat (30) @(negedge clk);
      check_poly("rst rerun", c0, b0, 4'h6, PolyIdB, OpMult);
      chk_drained("rst");

      // Edge operands: (q-1)*(q-1) -> 1, 0*x -> 0.
      q      = BW'(12289);
      length = LW'(4 * LS);
      @(negedge clk);
      c0 = cyc;
      b0 = n_pushed % 2;
      push_poly(4'h7, PolyIdA, OpMultAcc, 2, 0, 0);
      repeat (20) @(negedge clk);
      if (wr_q.size() > 0) chk("edge lane0", 64'(wr_q[0].da[BW-1:0]), 64'(1));
      if (wr_q.size() > 0) chk("edge lane1", 64'(wr_q[0].da[2*BW-1:BW]), 64'(0));
      check_poly("edge", c0, b0, 4'h7, PolyIdA, OpMultAcc);
      chk_drained("edge");

      chk("key addr tracks in addr", 64'(key_bad), 64'(0));
      chk("finish pulses coincide", 64'(fin_bad), 64'(0));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
